// File: rtl/stream_combiner_pkg.sv
// Shared definitions for the A/B add-sub stream combiner:
// mode bit positions, join FSM states and the result narrowing helper.
package stream_combiner_pkg;

    localparam int MODE_SAT   = 0;
    localparam int MODE_HALVE = 1;
    localparam int MODE_SWAP  = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DISC_A,
        S_DISC_B
    } state_t;

    // Clamp a sign-extended result to w bits when sat is set; the caller
    // keeps the low w bits, which is the wrap behaviour when sat is clear.
    function automatic logic signed [31:0] sat_wrap(
        input logic signed [31:0] v,
        input int                 w,
        input logic               sat
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (sat && v > hi) return hi;
        if (sat && v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/axis_fork_slot.sv
// One-entry output register with valid/ready, carrying data, user and last.
// Accepts a new beat whenever empty or draining in the same cycle.
module axis_fork_slot #(
    parameter int DW = 32,
    parameter int UW = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic [UW-1:0] i_user,
    input  logic          i_last,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [UW-1:0] o_user,
    output logic          o_last,
    output logic          o_can_accept
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [UW-1:0] r_user;
    logic          r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_user  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_user  <= i_user;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_can_accept = !r_valid || i_ready;
    assign o_valid      = r_valid;
    assign o_data       = r_data;
    assign o_user       = r_user;
    assign o_last       = r_last;

endmodule

// File: rtl/stream_addsub_combiner.sv
// Joins packetised complex streams A and B and forks A+B / A-B to two
// independently back-pressured outputs, with tlast mismatch recovery.
module stream_addsub_combiner
    import stream_combiner_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SR_MODE = 129,
    parameter int USER_W  = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_stb,
    input  logic [7:0]          set_addr,
    input  logic [31:0]         set_data,
    input  logic [2*WIDTH-1:0]  a_tdata,
    input  logic [USER_W-1:0]   a_tuser,
    input  logic                a_tlast,
    input  logic                a_tvalid,
    output logic                a_tready,
    input  logic [2*WIDTH-1:0]  b_tdata,
    input  logic                b_tlast,
    input  logic                b_tvalid,
    output logic                b_tready,
    output logic [2*WIDTH-1:0]  sum_tdata,
    output logic [USER_W-1:0]   sum_tuser,
    output logic                sum_tlast,
    output logic                sum_tvalid,
    input  logic                sum_tready,
    output logic [2*WIDTH-1:0]  diff_tdata,
    output logic [USER_W-1:0]   diff_tuser,
    output logic                diff_tlast,
    output logic                diff_tvalid,
    input  logic                diff_tready,
    output logic                err_mismatch,
    output logic [15:0]         err_count
);

    localparam int         DW      = 2 * WIDTH;
    localparam logic [7:0] SR_ADDR = 8'(SR_MODE);

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_mode;
    logic [2:0]          r_pkt_mode;
    logic [2:0]          w_mode;
    logic [USER_W-1:0]   r_user;
    logic [USER_W-1:0]   w_user;
    logic                w_join;
    logic                w_mm;
    logic                w_last;
    logic                w_sum_rdy;
    logic                w_diff_rdy;
    logic [DW-1:0]       w_sum;
    logic [DW-1:0]       w_diff;
    logic                r_err;
    logic [15:0]         r_err_cnt;
    logic                w_unused;

    assign w_unused = ^set_data[31:3];

    function automatic logic [WIDTH-1:0] arith(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             sub,
        input logic [2:0]       m
    );
        logic signed [31:0] xs;
        logic signed [31:0] ys;
        logic signed [31:0] r;
        xs = {{(32-WIDTH){x[WIDTH-1]}}, x};
        ys = {{(32-WIDTH){y[WIDTH-1]}}, y};
        r  = sub ? xs - ys : xs + ys;
        if (m[MODE_HALVE]) r = r >>> 1;
        r = sat_wrap(r, WIDTH, m[MODE_SAT]);
        return r[WIDTH-1:0];
    endfunction

    // The first beat of a packet runs with the live mode/tuser; later beats
    // reuse what that first beat latched.
    assign w_mode = (r_state == S_IDLE) ? r_mode : r_pkt_mode;
    assign w_user = (r_state == S_IDLE) ? a_tuser : r_user;
    assign w_last = a_tlast | b_tlast;

    always_comb begin
        w_sum[DW-1:WIDTH] = arith(a_tdata[DW-1:WIDTH],
                                  b_tdata[DW-1:WIDTH], 1'b0, w_mode);
        w_sum[WIDTH-1:0]  = arith(a_tdata[WIDTH-1:0],
                                  b_tdata[WIDTH-1:0], 1'b0, w_mode);
        if (w_mode[MODE_SWAP]) begin
            w_diff[DW-1:WIDTH] = arith(b_tdata[DW-1:WIDTH],
                                       a_tdata[DW-1:WIDTH], 1'b1, w_mode);
            w_diff[WIDTH-1:0]  = arith(b_tdata[WIDTH-1:0],
                                       a_tdata[WIDTH-1:0], 1'b1, w_mode);
        end else begin
            w_diff[DW-1:WIDTH] = arith(a_tdata[DW-1:WIDTH],
                                       b_tdata[DW-1:WIDTH], 1'b1, w_mode);
            w_diff[WIDTH-1:0]  = arith(a_tdata[WIDTH-1:0],
                                       b_tdata[WIDTH-1:0], 1'b1, w_mode);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_ACTIVE: begin
                if (w_join) begin
                    if (a_tlast && b_tlast) w_next = S_IDLE;
                    else if (a_tlast)       w_next = S_DISC_B;
                    else if (b_tlast)       w_next = S_DISC_A;
                    else                    w_next = S_ACTIVE;
                end
            end
            S_DISC_A: if (a_tvalid && a_tlast) w_next = S_IDLE;
            S_DISC_B: if (b_tvalid && b_tlast) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_join   = 1'b0;
        a_tready = 1'b0;
        b_tready = 1'b0;
        unique case (r_state)
            S_IDLE, S_ACTIVE: begin
                w_join   = !reset && a_tvalid && b_tvalid
                           && w_sum_rdy && w_diff_rdy;
                a_tready = w_join;
                b_tready = w_join;
            end
            S_DISC_A: a_tready = !reset;
            S_DISC_B: b_tready = !reset;
            default:  ;
        endcase
        w_mm = w_join && (a_tlast != b_tlast);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode     <= 3'b000;
            r_pkt_mode <= 3'b000;
            r_user     <= '0;
            r_err      <= 1'b0;
            r_err_cnt  <= 16'h0000;
        end else begin
            if (set_stb && set_addr == SR_ADDR) r_mode <= set_data[2:0];
            if (w_join && r_state == S_IDLE) begin
                r_pkt_mode <= r_mode;
                r_user     <= a_tuser;
            end
            r_err <= w_mm;
            if (w_mm && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_mismatch = r_err;
    assign err_count    = r_err_cnt;

    axis_fork_slot #(.DW(DW), .UW(USER_W)) u_sum (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_join),
        .i_data       (w_sum),
        .i_user       (w_user),
        .i_last       (w_last),
        .i_ready      (sum_tready),
        .o_valid      (sum_tvalid),
        .o_data       (sum_tdata),
        .o_user       (sum_tuser),
        .o_last       (sum_tlast),
        .o_can_accept (w_sum_rdy)
    );

    axis_fork_slot #(.DW(DW), .UW(USER_W)) u_diff (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_join),
        .i_data       (w_diff),
        .i_user       (w_user),
        .i_last       (w_last),
        .i_ready      (diff_tready),
        .o_valid      (diff_tvalid),
        .o_data       (diff_tdata),
        .o_user       (diff_tuser),
        .o_last       (diff_tlast),
        .o_can_accept (w_diff_rdy)
    );

endmodule

// File: tb/tb_stream_addsub_combiner.sv
// Scoreboard bench for stream_addsub_combiner: queued A/B drivers,
// expected SUM/DIFF beats checked by an independent output monitor.
module tb_stream_addsub_combiner;

    typedef struct packed {
        logic [31:0]  d;
        logic [127:0] u;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         set_stb;
    logic [7:0]   set_addr;
    logic [31:0]  set_data;
    logic [31:0]  a_tdata;
    logic [127:0] a_tuser;
    logic         a_tlast, a_tvalid, a_tready;
    logic [31:0]  b_tdata;
    logic         b_tlast, b_tvalid, b_tready;
    logic [31:0]  sum_tdata, diff_tdata;
    logic [127:0] sum_tuser, diff_tuser;
    logic         sum_tlast, sum_tvalid, sum_tready;
    logic         diff_tlast, diff_tvalid, diff_tready;
    logic         err_mismatch;
    logic [15:0]  err_count;

    beat_t a_beats[$];
    beat_t b_beats[$];
    beat_t sum_exp[$];
    beat_t diff_exp[$];

    int   n_vec   = 0;
    int   n_err   = 0;
    int   n_pulse = 0;
    logic flush   = 1'b0;
    logic rand_en = 1'b0;
    logic rdy_force = 1'b1;

    always #5 clk = ~clk;

    stream_addsub_combiner dut (
        .clk(clk), .reset(reset),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .a_tdata(a_tdata), .a_tuser(a_tuser), .a_tlast(a_tlast),
        .a_tvalid(a_tvalid), .a_tready(a_tready),
        .b_tdata(b_tdata), .b_tlast(b_tlast),
        .b_tvalid(b_tvalid), .b_tready(b_tready),
        .sum_tdata(sum_tdata), .sum_tuser(sum_tuser), .sum_tlast(sum_tlast),
        .sum_tvalid(sum_tvalid), .sum_tready(sum_tready),
        .diff_tdata(diff_tdata), .diff_tuser(diff_tuser),
        .diff_tlast(diff_tlast), .diff_tvalid(diff_tvalid),
        .diff_tready(diff_tready),
        .err_mismatch(err_mismatch), .err_count(err_count)
    );

    function automatic logic [31:0] pk(input int i, input int q);
        logic [15:0] hi;
        logic [15:0] lo;
        hi = 16'(i);
        lo = 16'(q);
        return {hi, lo};
    endfunction

    function automatic void chk(input string nm, input logic [63:0] got,
                                input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    function automatic void cmp_beat(input string nm, input beat_t e,
                                     input beat_t g);
        n_vec++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s: got d=%h u=%h l=%b expected d=%h u=%h l=%b",
                     nm, g.d, g.u, g.l, e.d, e.u, e.l);
        end
    endfunction

    task automatic push_a(input logic [31:0] d, input logic [127:0] u,
                          input logic l);
        beat_t bt;
        bt.d = d; bt.u = u; bt.l = l;
        a_beats.push_back(bt);
    endtask

    task automatic push_b(input logic [31:0] d, input logic l);
        beat_t bt;
        bt.d = d; bt.u = '0; bt.l = l;
        b_beats.push_back(bt);
    endtask

    task automatic expect_out(input logic [31:0] s, input logic [31:0] df,
                              input logic [127:0] u, input logic l);
        beat_t bt;
        bt.u = u; bt.l = l;
        bt.d = s;  sum_exp.push_back(bt);
        bt.d = df; diff_exp.push_back(bt);
    endtask

    // Aligned packet of n identical beats with its expected outputs.
    task automatic pkt(input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s, input logic [31:0] df,
                       input logic [127:0] u);
        for (int k = 0; k < n; k++) begin
            push_a(a, u, k == n - 1);
            push_b(b, k == n - 1);
            expect_out(s, df, u, k == n - 1);
        end
    endtask

    function automatic logic idle();
        return a_beats.size() == 0 && b_beats.size() == 0 && !a_tvalid
            && !b_tvalid && sum_exp.size() == 0 && diff_exp.size() == 0
            && !sum_tvalid && !diff_tvalid;
    endfunction

    task automatic drain(input string nm, input int lim);
        int k;
        for (k = 0; k < lim; k++) begin
            @(negedge clk);
            if (idle()) break;
        end
        if (k == lim) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: drain timeout, got %0d/%0d beats left expected 0",
                     nm, sum_exp.size(), diff_exp.size());
        end
    endtask

    task automatic wr_set(input logic [7:0] addr, input logic [31:0] d);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = addr; set_data = d;
        @(posedge clk); #1;
        set_stb = 1'b0;
    endtask

    initial begin : drv_a
        logic  hs;
        beat_t bt;
        a_tvalid = 1'b0; a_tdata = '0; a_tuser = '0; a_tlast = 1'b0;
        forever begin
            @(negedge clk);
            hs = a_tvalid && a_tready;
            @(posedge clk); #1;
            if (flush) begin
                a_tvalid = 1'b0;
            end else begin
                if (hs) a_tvalid = 1'b0;
                if (!a_tvalid && a_beats.size() > 0) begin
                    bt = a_beats.pop_front();
                    a_tdata = bt.d; a_tuser = bt.u; a_tlast = bt.l;
                    a_tvalid = 1'b1;
                end
            end
        end
    end

    initial begin : drv_b
        logic  hs;
        beat_t bt;
        b_tvalid = 1'b0; b_tdata = '0; b_tlast = 1'b0;
        forever begin
            @(negedge clk);
            hs = b_tvalid && b_tready;
            @(posedge clk); #1;
            if (flush) begin
                b_tvalid = 1'b0;
            end else begin
                if (hs) b_tvalid = 1'b0;
                if (!b_tvalid && b_beats.size() > 0) begin
                    bt = b_beats.pop_front();
                    b_tdata = bt.d; b_tlast = bt.l;
                    b_tvalid = 1'b1;
                end
            end
        end
    end

    initial begin : drv_rdy
        sum_tready = 1'b0;
        diff_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rand_en) begin
                sum_tready  = ($urandom_range(3) != 0);
                diff_tready = ($urandom_range(3) != 0);
            end else begin
                sum_tready  = rdy_force;
                diff_tready = rdy_force;
            end
        end
    end

    always @(negedge clk) begin : monitor
        beat_t e;
        beat_t g;
        if (err_mismatch) n_pulse++;
        if (sum_tvalid && sum_tready) begin
            g.d = sum_tdata; g.u = sum_tuser; g.l = sum_tlast;
            if (sum_exp.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sum_extra: got d=%h expected no beat", g.d);
            end else begin
                e = sum_exp.pop_front();
                cmp_beat("sum_beat", e, g);
            end
        end
        if (diff_tvalid && diff_tready) begin
            g.d = diff_tdata; g.u = diff_tuser; g.l = diff_tlast;
            if (diff_exp.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL diff_extra: got d=%h expected no beat", g.d);
            end else begin
                e = diff_exp.pop_front();
                cmp_beat("diff_beat", e, g);
            end
        end
    end

    initial begin : main
        logic [127:0] u;
        int           run;
        int           k;
        reset = 1'b1;
        set_stb = 1'b0; set_addr = '0; set_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {62'd0, sum_tvalid, diff_tvalid}, 64'd0);
        chk("rst_last", {62'd0, sum_tlast, diff_tlast}, 64'd0);
        chk("rst_ready", {62'd0, a_tready, b_tready}, 64'd0);
        chk("rst_data", {sum_tdata, diff_tdata}, 64'd0);
        chk("rst_user", sum_tuser[63:0] | diff_tuser[63:0], 64'd0);
        chk("rst_err", {47'd0, err_mismatch, err_count}, 64'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        // 1: basic add/sub, latency and throughput
        u = 128'hA1;
        pkt(4, pk(100, -5), pk(20, 7), pk(120, 2), pk(80, -12), u);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (a_tvalid && a_tready) break;
        end
        if (k == 50) begin
            n_vec++; n_err++;
            $display("FAIL t1_join: got no join expected join within 50");
        end
        run = 1;
        @(negedge clk);
        chk("t1_latency", {62'd0, sum_tvalid, diff_tvalid}, 64'd3);
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            if (a_tvalid && a_tready && b_tready) run++;
        end
        chk("t1_throughput", 64'(run), 64'd4);
        drain("t1", 200);

        // 2: saturate / wrap / ignored address / halve
        wr_set(8'd129, 32'd1);
        pkt(1, pk(32767, -32768), pk(32767, -32768),
            pk(32767, -32768), pk(0, 0), 128'hB1);
        drain("t2_sat", 200);
        wr_set(8'd129, 32'd0);
        wr_set(8'd128, 32'd1);
        pkt(1, pk(32767, -32768), pk(32767, -32768),
            pk(-2, 0), pk(0, 0), 128'hB2);
        drain("t2_wrap", 200);
        wr_set(8'd129, 32'd2);
        pkt(1, pk(32767, -32768), pk(32767, -32768),
            pk(32767, -32768), pk(0, 0), 128'hB3);
        drain("t2_halve", 200);

        // 3: swap + halve
        wr_set(8'd129, 32'd6);
        pkt(2, pk(3, 0), pk(10, 0), pk(6, 0), pk(3, 0), 128'hC1);
        drain("t3", 200);

        // 4: random back-pressure, 1000 beats
        wr_set(8'd129, 32'd0);
        rand_en = 1'b1;
        for (int p = 0; p < 250; p++) begin
            u = {96'hD00D, 32'(p)};
            for (int j = 0; j < 4; j++) begin
                push_a(pk(p * 7 + j, -(j * 3)), u, j == 3);
                push_b(pk(j + 1, p % 50), j == 3);
                expect_out(pk(p * 7 + j + j + 1, -(j * 3) + p % 50),
                           pk(p * 7 + j - j - 1, -(j * 3) - p % 50),
                           u, j == 3);
            end
        end
        drain("t4", 20000);
        rand_en = 1'b0;

        // 5: A ends at beat 3, B at beat 5; then an aligned packet
        u = 128'hE1;
        for (int j = 0; j < 3; j++) begin
            push_a(pk(1, 2), u, j == 2);
            expect_out(pk(4, 6), pk(-2, -2), u, j == 2);
        end
        for (int j = 0; j < 5; j++) push_b(pk(3, 4), j == 4);
        pkt(2, pk(5, 5), pk(1, 1), pk(6, 6), pk(4, 4), 128'hE2);
        drain("t5", 400);
        chk("t5_err_count", 64'(err_count), 64'd1);
        chk("t5_pulses", 64'(n_pulse), 64'd1);

        // 6: reset mid-packet with both outputs stalled
        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        pkt(4, pk(9, 9), pk(1, 1), pk(10, 10), pk(8, 8), 128'hF0);
        repeat (8) @(negedge clk);
        chk("t6_stalled", {61'd0, sum_tvalid, diff_tvalid, a_tready},
            64'd6);
        @(posedge clk); #2;
        reset = 1'b1;
        flush = 1'b1;
        #1;
        chk("t6_rst_valid", {62'd0, sum_tvalid, diff_tvalid}, 64'd0);
        chk("t6_rst_err", 64'(err_count), 64'd0);
        a_beats.delete(); b_beats.delete();
        sum_exp.delete(); diff_exp.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk); #2;
        flush = 1'b0;
        rdy_force = 1'b1;
        pkt(2, pk(-7, 30), pk(2, -40), pk(-5, -10), pk(-9, 70), 128'hF1);
        drain("t6", 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
